sat_subtractor_stream: RTL
==========================

# sat_subtractor_stream

Registered, saturating signed subtractor (difference = minuend − subtrahend) with a valid/ready stream interface and a 2-entry skid buffer. It is the inverse companion of the saturating adder in the ESPNet datapath: it removes a residual or bias term, or forms a difference, between two aligned 17-bit fixed-point streams. The handshake lets it sit between back-pressured convolution and merge stages. Saturation events are flagged per result and counted for debug.

## Interface
- data_width, 17, signed two's-complement width of operands and result
- count_width, 16, width of the saturation event counter

- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state
- enable  input  1  clock enable; when low, all registers hold and handshakes do not complete
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- minuend  input  data_width  signed operand A
- subtrahend  input  data_width  signed operand B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- difference  output  data_width  saturated A − B
- sat_pos  output  1  current result clamped to MAX
- sat_neg  output  1  current result clamped to MIN
- sat_count  output  count_width  number of accepted saturated results, sticky at all-ones

## Operation
- MAX = 0 followed by ones (65535 at width 17). MIN = 1 followed by zeros (−65536 at width 17).
- raw = A − B, truncated to data_width.
- Positive overflow: A[msb]=0, B[msb]=1, raw[msb]=1. Result is MAX, sat_pos=1.
- Negative overflow: A[msb]=1, B[msb]=0, raw[msb]=0. Result is MIN, sat_neg=1.
- Otherwise result is raw and both flags are 0. sat_pos and sat_neg are never both 1.
- Input accept: in_valid & in_ready & enable.
- Output accept: out_valid & out_ready & enable.
- Storage: main slot (drives outputs) and skid slot. Each slot holds {difference, sat_pos, sat_neg}.
- States:
  - EMPTY: nothing held.
  - ONE: main valid.
  - FULL: main and skid valid.
- Transitions, evaluated only when enable=1:
  - EMPTY → ONE on input accept.
  - ONE → ONE on input and output accept together (main reloads).
  - ONE → EMPTY on output accept only.
  - ONE → FULL on input accept only (new result goes to skid).
  - FULL → ONE on output accept (skid moves to main).
- Outputs: in_ready = (state != FULL). out_valid = (state != EMPTY). Both are driven directly from registers.
- sat_count increments by 1 when an input is accepted and its result saturates. It holds at all-ones once reached.

## Timing
- Latency is 1 cycle: a result accepted at edge N is valid on out_valid after edge N. Full throughput is one result per cycle while out_ready=1.
- in_ready depends only on state, never combinationally on out_ready. Because in_ready is low in FULL, no input is accepted there, so the held data cannot be lost.
- difference, sat_pos and sat_neg stay stable while out_valid=1 and out_ready=0.
- enable=0: state, data and counter freeze, and accept conditions are false. in_ready and out_valid keep their current values.
- Reset, applied regardless of enable, takes effect at the next edge:
  - state = EMPTY
  - in_ready = 1
  - out_valid = 0
  - difference = 0, sat_pos = 0, sat_neg = 0
  - sat_count = 0
- Reset mid-operation discards both slots. Results in flight are dropped without being delivered.

## Structure
- Shared package holds:
  - the state encoding (EMPTY/ONE/FULL)
  - a function returning MAX and MIN for a given data_width
  - the slot record typedef {difference, sat_pos, sat_neg}
- One sub-module, sat_sub_core: purely combinational. Takes A and B; produces the saturated result and the two flags.
- The top level contains the skid FSM, the two slots and the counter.

## Test plan
- Reset, then 1000 − 250 with out_ready=1 → 750 one cycle later, flags 0, sat_count 0.
- 65535 − (−1) → 65535, sat_pos=1. Then −65536 − 1 → −65536, sat_neg=1. sat_count=2.
- out_ready=0 while sending 3 operand pairs:
  - pairs 1 and 2 accepted; in_ready falls after the second accept.
  - pair 3 is stalled.
  - raise out_ready → results emerge in order, no loss or duplication.
- enable low for 5 cycles mid-stream → outputs and state unchanged. Resuming enable continues the stream exactly.
- Force sat_count to all-ones (count_width=4, 16 saturating inputs), then 1 more saturating input → sat_count holds at 15.
- Assert reset while FULL → next cycle out_valid=0, in_ready=1, difference=0, sat_count=0. Held results are never delivered.

Source files
------------

// File: rtl/sat_subtractor_stream_pkg.sv
// Shared definitions for the saturating stream subtractor.
//   - DATA_W   : operand/result width (signed two's complement)
//   - state_t  : skid buffer occupancy (EMPTY / ONE / FULL)
//   - slot_t   : one held result {diff, sat_pos, sat_neg}
//   - sat_limit: MAX or MIN representable value for a given width
package sat_subtractor_stream_pkg;

  localparam int DATA_W = 17;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] diff;
    logic                     sat_pos;
    logic                     sat_neg;
  } slot_t;

  // hi=1 returns MAX (0 followed by ones), hi=0 returns MIN (1 followed by zeros).
  function automatic logic signed [31:0] sat_limit(input int w, input logic hi);
    logic signed [31:0] one_msb;
    one_msb = 32'sd1 <<< (w - 1);
    return hi ? (one_msb - 32'sd1) : -one_msb;
  endfunction

  localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'(sat_limit(DATA_W, 1'b1));
  localparam logic signed [DATA_W-1:0] SAT_MIN = DATA_W'(sat_limit(DATA_W, 1'b0));

endpackage

// File: rtl/sat_subtractor_stream_sat_sub_core.sv
// Combinational saturating subtract: o_diff = clamp(i_a - i_b).
//   i_a, i_b   : signed operands (minuend, subtrahend)
//   o_diff     : saturated difference
//   o_sat_pos  : result was clamped to MAX
//   o_sat_neg  : result was clamped to MIN
module sat_sub_core
  import sat_subtractor_stream_pkg::*;
(
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_diff,
  output logic                     o_sat_pos,
  output logic                     o_sat_neg
);

  // Overflow on subtraction is only possible when the operand signs differ;
  // it shows up as the wrapped result taking the subtrahend's sign.
  function automatic slot_t saturate(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] raw;
    slot_t s;
    raw       = a - b;
    s.diff    = raw;
    s.sat_pos = 1'b0;
    s.sat_neg = 1'b0;
    if (!a[DATA_W-1] && b[DATA_W-1] && raw[DATA_W-1]) begin
      s.diff    = SAT_MAX;
      s.sat_pos = 1'b1;
    end else if (a[DATA_W-1] && !b[DATA_W-1] && !raw[DATA_W-1]) begin
      s.diff    = SAT_MIN;
      s.sat_neg = 1'b1;
    end
    return s;
  endfunction

  slot_t w_res;

  assign w_res     = saturate(i_a, i_b);
  assign o_diff    = w_res.diff;
  assign o_sat_pos = w_res.sat_pos;
  assign o_sat_neg = w_res.sat_neg;

endmodule

// File: rtl/sat_subtractor_stream.sv
// Registered saturating subtractor with valid/ready handshake and a
// 2-entry skid buffer (main slot drives the outputs, skid slot absorbs one
// extra result so in_ready never depends combinationally on out_ready).
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_enable            : clock enable; freezes everything when low
//   i_in_valid/o_in_ready, i_minuend, i_subtrahend : input stream
//   o_out_valid/i_out_ready, o_difference, o_sat_pos, o_sat_neg : output stream
//   o_sat_count         : saturated results accepted, sticky at all-ones
module sat_subtractor_stream
  import sat_subtractor_stream_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic signed [DATA_W-1:0] i_minuend,
  input  logic signed [DATA_W-1:0] i_subtrahend,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic signed [DATA_W-1:0] o_difference,
  output logic                     o_sat_pos,
  output logic                     o_sat_neg,
  output logic [COUNT_W-1:0]       o_sat_count
);

  state_t             r_state;
  slot_t              r_main;
  slot_t              r_skid;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [COUNT_W-1:0] r_sat_count;

  slot_t w_new;
  logic  w_in_acc;
  logic  w_out_acc;

  sat_sub_core u_core (
    .i_a       (i_minuend),
    .i_b       (i_subtrahend),
    .o_diff    (w_new.diff),
    .o_sat_pos (w_new.sat_pos),
    .o_sat_neg (w_new.sat_neg)
  );

  assign w_in_acc  = i_in_valid & r_in_ready & i_enable;
  assign w_out_acc = r_out_valid & i_out_ready & i_enable;

  // Register stage: skid FSM, slots and saturation counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sat_count <= '0;
    end else if (i_enable) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_acc) begin
            r_main      <= w_new;
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_acc && w_out_acc) begin
            r_main <= w_new;
          end else if (w_out_acc) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end else if (w_in_acc) begin
            r_skid     <= w_new;
            r_state    <= ST_FULL;
            r_in_ready <= 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the output side can move.
          if (w_out_acc) begin
            r_main     <= r_skid;
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase

      if (w_in_acc && (w_new.sat_pos || w_new.sat_neg) && (r_sat_count != '1)) begin
        r_sat_count <= r_sat_count + COUNT_W'(1);
      end
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_out_valid  = r_out_valid;
  assign o_difference = r_main.diff;
  assign o_sat_pos    = r_main.sat_pos;
  assign o_sat_neg    = r_main.sat_neg;
  assign o_sat_count  = r_sat_count;

endmodule
